// File: rtl/accel_core_seq_if.sv
// accel_core_seq_if
//   Request/response channel between the job sequencer and the compute engine.
//   master : sequencer side (drives req_valid/req_addr/req_last)
//   slave  : engine side    (drives req_ready/rsp_valid)
//   req_valid/req_ready  valid/ready handshake for one word request
//   req_addr             word address of the request
//   req_last             marks the final request of the job
//   rsp_valid            one-cycle pulse per completed request
interface accel_core_seq_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_last;
   logic              rsp_valid;

   modport master (
      output req_valid, req_addr, req_last,
      input  req_ready, rsp_valid
   );

   modport slave (
      input  req_valid, req_addr, req_last,
      output req_ready, rsp_valid
   );
endinterface

// File: rtl/accel_core_seq.sv
// accel_core_seq
//   Job sequencer fed by the accelerator control register map. A rising edge
//   of CTRL.start latches (base, len, stride) and issues one address request
//   per word to the engine; completions are counted and reported as status.
//   CTRL.abort stops issuing after any in-flight request and drains responses.
// Ports:
//   aclk, aresetn  clock, synchronous active-low reset
//   mmap           register array: [0] CTRL (b0 start, b1 abort), [1] SRC_BASE,
//                  [2] LEN, [3] STRIDE
//   req_if         engine request/response channel (master side)
//   busy, done     job in progress / sticky job finished
//   err            0 ok, 1 zero length, 2 aborted
//   issued_cnt     requests accepted this job
//   rsp_cnt        completions counted this job
module accel_core_seq #(
   parameter int MMAP_DEPTH = 8,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 16
) (
   input  logic                                aclk,
   input  logic                                aresetn,
   input  logic [MMAP_DEPTH-1:0][DATA_W-1:0]   mmap,
   accel_core_seq_if.master                    req_if,
   output logic                                busy,
   output logic                                done,
   output logic [1:0]                          err,
   output logic [CNT_W-1:0]                    issued_cnt,
   output logic [CNT_W-1:0]                    rsp_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT, S_DONE} state_t;

   state_t            state, state_nxt;
   logic              start_prev;
   logic              abort_pend;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] stride_r;
   logic [CNT_W-1:0]  len_r;
   logic [1:0]        err_r;

   // only the low fields of the first four entries matter; fold the rest away
   logic unused_mmap;
   assign unused_mmap = ^mmap;

   logic              start_bit, abort_bit, start_edge, start_ok;
   logic [ADDR_W-1:0] base_in, stride_in;
   logic [CNT_W-1:0]  len_in;
   logic              hs, rsp_inc, abort_any, last_req;
   logic [CNT_W-1:0]  issued_nxt, rsp_nxt;

   assign start_bit  = mmap[0][0];
   assign abort_bit  = mmap[0][1];
   assign base_in    = mmap[1][ADDR_W-1:0];
   assign len_in     = mmap[2][CNT_W-1:0];
   assign stride_in  = mmap[3][ADDR_W-1:0];

   assign start_edge = start_bit & ~start_prev;
   // a start edge only counts while no job is running
   assign start_ok   = start_edge && (state == S_IDLE || state == S_DONE);
   // req_valid is exactly "in ISSUE", so the handshake is decoded from state
   assign hs         = (state == S_ISSUE) && req_if.req_ready;
   assign last_req   = (issued_cnt == len_r - CNT_W'(1));
   // an abort seen while stalled is remembered until the pending word is taken
   assign abort_any  = abort_bit | abort_pend;
   // responses beyond what was issued are spurious and dropped
   assign rsp_inc    = req_if.rsp_valid && state != S_IDLE && state != S_DONE &&
                       rsp_cnt != issued_cnt;
   assign issued_nxt = issued_cnt + CNT_W'(hs);
   assign rsp_nxt    = rsp_cnt + CNT_W'(rsp_inc);

   // state register
   always_ff @(posedge aclk) begin
      if (!aresetn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // next-state logic; completion checks use post-update counters so DONE
   // lands on the same edge that counts the final response
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start_ok) state_nxt = (len_in == '0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            if (hs) begin
               if (abort_any)     state_nxt = S_ABORT;
               else if (last_req) state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (rsp_nxt == len_r) state_nxt = S_DONE;
            else if (abort_bit)   state_nxt = S_ABORT;
         end
         S_ABORT: begin
            if (rsp_nxt == issued_nxt) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // output decode
   always_comb begin
      busy             = (state == S_ISSUE) || (state == S_WAIT) || (state == S_ABORT);
      done             = (state == S_DONE);
      req_if.req_valid = (state == S_ISSUE);
      req_if.req_last  = (state == S_ISSUE) && last_req;
      req_if.req_addr  = addr_r;
      err              = err_r;
   end

   // descriptor, address walker, counters and status
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         start_prev <= 1'b0;
         abort_pend <= 1'b0;
         addr_r     <= '0;
         stride_r   <= '0;
         len_r      <= '0;
         issued_cnt <= '0;
         rsp_cnt    <= '0;
         err_r      <= 2'd0;
      end else begin
         start_prev <= start_bit;
         abort_pend <= (state == S_ISSUE) && abort_any && !hs;
         if (start_ok) begin
            addr_r     <= base_in;
            stride_r   <= stride_in;
            len_r      <= len_in;
            issued_cnt <= '0;
            rsp_cnt    <= '0;
            err_r      <= (len_in == '0) ? 2'd1 : 2'd0;
         end else begin
            // addr_r tracks base + issued_cnt*stride incrementally (wraps)
            if (hs) begin
               issued_cnt <= issued_nxt;
               addr_r     <= addr_r + stride_r;
            end
            if (rsp_inc) rsp_cnt <= rsp_nxt;
            if (state == S_ABORT && state_nxt == S_DONE) err_r <= 2'd2;
         end
      end
   end

endmodule

// File: doc/accel_core_seq.md
# accel_core_seq

Job sequencer directly downstream of the accelerator control register map. It samples the register array written by host software. On a rising edge of the start bit it latches the job descriptor (base, length, stride) and issues one address request per word to the compute engine over a valid/ready channel. It counts engine completions and reports busy/done/error status. It supports software abort with a clean drain of outstanding requests.

## Interface
Parameters:
- MMAP_DEPTH, 8: number of register-map entries (must be ≥ 4).
- DATA_W, 32: width of each register-map entry.
- ADDR_W, 32: request address width (≤ DATA_W).
- CNT_W, 16: job length / counter width.

Ports:
- aclk  in  1  single clock.
- aresetn  in  1  reset; synchronous and active-low.
- mmap  in  MMAP_DEPTH x DATA_W  register array from the control map:
  - [0] CTRL: bit0 start, bit1 abort.
  - [1] SRC_BASE.
  - [2] LEN: low CNT_W bits.
  - [3] STRIDE: low ADDR_W bits.
- req_valid  out  1  request valid to engine.
- req_ready  in  1  engine accepts request.
- req_addr  out  ADDR_W  request address.
- req_last  out  1  final request of job.
- rsp_valid  in  1  one-cycle pulse per completed request.
- busy  out  1  job in progress.
- done  out  1  sticky job-finished flag.
- err  out  2  0 OK, 1 zero length, 2 aborted.
- issued_cnt  out  CNT_W  requests accepted this job.
- rsp_cnt  out  CNT_W  completions counted this job.

## Operation
- Start detect: registered copy of mmap[0][0]; start_edge = bit0 & ~prev. Level-high start without an edge does nothing.
- States: IDLE, ISSUE, WAIT, ABORT, DONE.
- IDLE / DONE, start_edge:
  - Latch base = mmap[1][ADDR_W-1:0], len = mmap[2][CNT_W-1:0], stride = mmap[3][ADDR_W-1:0].
  - Clear both counters; clear done and err.
  - If len == 0: go to DONE with err = 1.
  - Otherwise: go to ISSUE.
- ISSUE:
  - req_valid = 1.
  - req_addr = base + issued_cnt * stride, truncated mod 2^ADDR_W (wrap-around allowed).
  - req_last = (issued_cnt == len-1).
  - Each req_valid & req_ready cycle increments issued_cnt.
  - Handshake on the last request: go to WAIT.
- WAIT: no requests. When rsp_cnt == len: go to DONE with err = 0.
- rsp_valid: increments rsp_cnt in any non-IDLE state, including the same cycle as a request handshake.
  - Ignored when rsp_cnt == issued_cnt (spurious).
  - Ignored in IDLE and DONE.
- Abort (mmap[0][1] level), sampled in ISSUE or WAIT:
  - If req_valid is high and req_ready is low, the current request stays valid until it is accepted.
  - No further requests are issued after that.
  - Go to ABORT.
- ABORT: when rsp_cnt == issued_cnt, go to DONE with err = 2.
- Abort has no effect in IDLE or DONE.
- busy = 1 in ISSUE, WAIT and ABORT.
- done = 1 only in DONE; it holds until the next start_edge.
- Descriptor registers are frozen during a job. Software writes to mmap[1..3] mid-job do not affect the running job.
- start_edge while busy is ignored. The edge detector still updates, so a held start bit does not retrigger later.

## Timing
- Reset (aresetn = 0 at a clock edge):
  - State IDLE.
  - req_valid, req_last, busy, done = 0; err = 0; issued_cnt, rsp_cnt = 0; req_addr = 0.
  - Start history register = 0: a start bit already high when reset releases produces an edge on the first sampled cycle.
- Reset mid-job: immediate return to IDLE. Outstanding engine responses after reset are ignored (IDLE).
- Latency from start edge to first request:
  - Start bit seen high at edge N (prev = 0): state ISSUE and req_valid = 1 from cycle N+1, with req_addr = base.
- Back-to-back issue: with req_ready held high, one request per cycle. The last request is accepted at cycle N+len.
- Completion: the cycle rsp_cnt reaches len is registered. DONE, done = 1 and busy = 0 appear one cycle after the final rsp_valid.
- Zero length: DONE, done = 1, err = 1 at cycle N+1. No request is issued.
- Request outputs: all registered. req_addr and req_last are stable while req_valid is high and req_ready is low.
- Abort latency: state ABORT one cycle after abort is sampled, or one cycle after the pending handshake completes.

## Test plan
- Basic job: base=0x1000, len=4, stride=4, req_ready=1, rsp_valid one cycle after each handshake.
  - Expect addresses 0x1000, 0x1004, 0x1008, 0x100C, with req_last on 0x100C.
  - Expect done=1, err=0, issued_cnt=rsp_cnt=4.
- Backpressure: req_ready toggling 1,0,0,1, len=3.
  - Expect req_addr/req_last held steady while stalled.
  - Expect exactly 3 handshakes and no duplicate or skipped address.
- Zero length and wrap:
  - len=0: expect done=1, err=1 at cycle N+1 and no req_valid.
  - base=0xFFFFFFF8, stride=8, len=3: expect addresses 0xFFFFFFF8, 0x00000000, 0x00000008.
- Abort mid-job: len=10, abort raised after 3 handshakes with 1 response returned, req_ready low at abort.
  - Expect the pending 4th request to complete, then no more requests.
  - Expect done only after rsp_cnt=4, with err=2.
- Start edge rules:
  - Start held high across job end: no second job.
  - Start toggled 0→1 while busy: ignored.
  - Descriptor changed mid-job: addresses unchanged.
  - Start toggled 0→1 in DONE: done clears, new job runs.
- Reset mid-ISSUE: aresetn=0 for 1 cycle at issued_cnt=2.
  - Expect all outputs at reset values next cycle.
  - Expect later rsp_valid pulses ignored (rsp_cnt stays 0).
